// File: rtl/dca_matrix_merger.sv
// Collects result tile rows and issues one row write per valid row, rebuilding the
// destination matrix. Edge tiles are clipped by column mask and by dropping rows.
module dca_matrix_merger #(
  parameter int NUM_ROW = 8,
  parameter int NUM_COL = 8,
  parameter int BW_ADDR = 32,
  parameter int BW_DIM  = 16
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   start,
  input  logic [BW_ADDR-1:0]     dst_addr,
  input  logic [BW_ADDR-1:0]     dst_stride,
  input  logic [BW_DIM-1:0]      num_row_m1,
  input  logic [BW_DIM-1:0]      num_col_m1,
  input  logic                   is_col_first,
  input  logic                   row_valid,
  output logic                   row_ready,
  input  logic [32*NUM_COL-1:0]  row_data,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [BW_ADDR-1:0]     wr_addr,
  output logic [32*NUM_COL-1:0]  wr_data,
  output logic [NUM_COL-1:0]     wr_mask,
  output logic                   wr_last,
  output logic                   busy,
  output logic                   done
);

  localparam int LOG_R = $clog2(NUM_ROW);
  localparam int LOG_C = $clog2(NUM_COL);
  localparam int RW    = (NUM_ROW > 1) ? LOG_R : 1;
  localparam int IW    = BW_DIM + LOG_R + 1;
  localparam int CW    = BW_DIM + LOG_C + 1;
  localparam logic [BW_ADDR-1:0] COL_STEP = BW_ADDR'(NUM_COL * 4);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [BW_ADDR-1:0]     dst_q, dst_d, stride_q, stride_d;
  logic [BW_DIM-1:0]      rowM1_q, rowM1_d, colM1_q, colM1_d;
  logic                   colFirst_q, colFirst_d;
  logic [BW_DIM-1:0]      txLast_q, txLast_d, tyLast_q, tyLast_d;
  logic [BW_DIM-1:0]      tx_q, tx_d, ty_q, ty_d;
  logic [RW-1:0]          r_q, r_d;
  logic [BW_ADDR-1:0]     tileRowBase_q, tileRowBase_d, rowBase_q, rowBase_d;
  logic [BW_ADDR-1:0]     colOff_q, colOff_d;
  logic                   wrValid_q, wrValid_d, wrLast_q, wrLast_d;
  logic [BW_ADDR-1:0]     wrAddr_q, wrAddr_d;
  logic [32*NUM_COL-1:0]  wrData_q, wrData_d;
  logic [NUM_COL-1:0]     wrMask_q, wrMask_d;

  logic [IW-1:0]          rowIdx;
  logic                   rowOk, rWrap, txEnd, tyEnd, lastBeat, xfer, wrDone, doneNow;
  logic [NUM_COL-1:0]     colMask;
  logic [BW_ADDR-1:0]     tileStep;

  assign rowIdx   = (IW'(ty_q) << LOG_R) | IW'(r_q);
  assign rowOk    = rowIdx <= IW'(rowM1_q);
  assign rWrap    = (r_q == RW'(NUM_ROW - 1));
  assign txEnd    = (tx_q == txLast_q);
  assign tyEnd    = (ty_q == tyLast_q);
  assign lastBeat = rWrap & txEnd & tyEnd;
  assign tileStep = stride_q << LOG_R;

  assign row_ready = enable & (state_q == RUN) & (!wrValid_q | wr_ready);
  assign xfer      = row_valid & row_ready;
  assign wrDone    = enable & wrValid_q & wr_ready;
  assign doneNow   = !clear & enable & (state_q == DRAIN) & !wrValid_q;

  always_comb begin
    colMask = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      colMask[c] = ((CW'(tx_q) << LOG_C) + CW'(c)) <= CW'(colM1_q);
    end
  end

  // Next-state: clear dominates; otherwise nothing moves unless enable is high.
  always_comb begin
    state_d       = state_q;
    dst_d         = dst_q;
    stride_d      = stride_q;
    rowM1_d       = rowM1_q;
    colM1_d       = colM1_q;
    colFirst_d    = colFirst_q;
    txLast_d      = txLast_q;
    tyLast_d      = tyLast_q;
    tx_d          = tx_q;
    ty_d          = ty_q;
    r_d           = r_q;
    tileRowBase_d = tileRowBase_q;
    rowBase_d     = rowBase_q;
    colOff_d      = colOff_q;
    wrValid_d     = wrValid_q;
    wrLast_d      = wrLast_q;
    wrAddr_d      = wrAddr_q;
    wrData_d      = wrData_q;
    wrMask_d      = wrMask_q;

    if (clear) begin
      state_d       = IDLE;
      wrValid_d     = 1'b0;
      tx_d          = '0;
      ty_d          = '0;
      r_d           = '0;
      tileRowBase_d = '0;
      rowBase_d     = '0;
      colOff_d      = '0;
    end else if (enable) begin
      if (wrDone) wrValid_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d       = RUN;
            dst_d         = dst_addr;
            stride_d      = dst_stride;
            rowM1_d       = num_row_m1;
            colM1_d       = num_col_m1;
            colFirst_d    = is_col_first;
            txLast_d      = num_col_m1 >> LOG_C;
            tyLast_d      = num_row_m1 >> LOG_R;
            tx_d          = '0;
            ty_d          = '0;
            r_d           = '0;
            tileRowBase_d = dst_addr;
            rowBase_d     = dst_addr;
            colOff_d      = '0;
          end
        end
        RUN: begin
          if (xfer) begin
            if (rowOk) begin
              wrValid_d = 1'b1;
              wrAddr_d  = rowBase_q + colOff_q;
              wrData_d  = row_data;
              wrMask_d  = colMask;
              wrLast_d  = txEnd & tyEnd & (rowIdx == IW'(rowM1_q));
            end
            if (lastBeat) state_d = DRAIN;
            // rowBase tracks dst + row*stride; moving down a row or into the next
            // tile row below is always one more stride from the current row.
            if (!rWrap) begin
              r_d       = r_q + 1'b1;
              rowBase_d = rowBase_q + stride_q;
            end else begin
              r_d = '0;
              if (!colFirst_q) begin
                if (!txEnd) begin
                  tx_d      = tx_q + 1'b1;
                  colOff_d  = colOff_q + COL_STEP;
                  rowBase_d = tileRowBase_q;
                end else begin
                  tx_d          = '0;
                  colOff_d      = '0;
                  ty_d          = ty_q + 1'b1;
                  tileRowBase_d = tileRowBase_q + tileStep;
                  rowBase_d     = rowBase_q + stride_q;
                end
              end else begin
                if (!tyEnd) begin
                  ty_d          = ty_q + 1'b1;
                  tileRowBase_d = tileRowBase_q + tileStep;
                  rowBase_d     = rowBase_q + stride_q;
                end else begin
                  ty_d          = '0;
                  tileRowBase_d = dst_q;
                  rowBase_d     = dst_q;
                  tx_d          = tx_q + 1'b1;
                  colOff_d      = colOff_q + COL_STEP;
                end
              end
            end
          end
        end
        DRAIN: begin
          if (!wrValid_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q       <= IDLE;
      dst_q         <= '0;
      stride_q      <= '0;
      rowM1_q       <= '0;
      colM1_q       <= '0;
      colFirst_q    <= 1'b0;
      txLast_q      <= '0;
      tyLast_q      <= '0;
      tx_q          <= '0;
      ty_q          <= '0;
      r_q           <= '0;
      tileRowBase_q <= '0;
      rowBase_q     <= '0;
      colOff_q      <= '0;
      wrValid_q     <= 1'b0;
      wrLast_q      <= 1'b0;
      wrAddr_q      <= '0;
      wrData_q      <= '0;
      wrMask_q      <= '0;
    end else begin
      state_q       <= state_d;
      dst_q         <= dst_d;
      stride_q      <= stride_d;
      rowM1_q       <= rowM1_d;
      colM1_q       <= colM1_d;
      colFirst_q    <= colFirst_d;
      txLast_q      <= txLast_d;
      tyLast_q      <= tyLast_d;
      tx_q          <= tx_d;
      ty_q          <= ty_d;
      r_q           <= r_d;
      tileRowBase_q <= tileRowBase_d;
      rowBase_q     <= rowBase_d;
      colOff_q      <= colOff_d;
      wrValid_q     <= wrValid_d;
      wrLast_q      <= wrLast_d;
      wrAddr_q      <= wrAddr_d;
      wrData_q      <= wrData_d;
      wrMask_q      <= wrMask_d;
    end
  end

  assign wr_valid = wrValid_q;
  assign wr_addr  = wrAddr_q;
  assign wr_data  = wrData_q;
  assign wr_mask  = wrMask_q;
  assign wr_last  = wrLast_q;
  assign busy     = (state_q != IDLE);
  assign done     = doneNow;

endmodule
